// File: rtl/stage_pkg.sv
// Shared pipeline-stage types: the bundle handed from fetch to read, and fetch FSM states.
package stage;

  localparam int INSN_SIZE   = 4;
  localparam int WORD_ADDR_W = 30;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [31:0]            insn;
  } InsnBundle;

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem request/response, redirect, stall and the outgoing bundle.
interface fetch_stage_if #(parameter int ADDR_WIDTH = 32);
  import stage::*;

  logic                  imem_req_valid;
  logic [ADDR_WIDTH-3:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-3:0] redirect_addr;
  logic                  stall;
  logic                  out_valid;
  InsnBundle             out_insn;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_insn,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_addr, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_insn,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_addr, stall
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a response that arrives while the output slot is stalled.
module fetch_skid_buffer
  import stage::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  logic      unload_i,
  input  logic      flush_i,
  input  InsnBundle data_i,
  output logic      valid_o,
  output InsnBundle data_o
);

  logic      valid_q;
  InsnBundle data_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC owner, single-outstanding imem requests, skid on stall, drop-on-flight redirect.
// Optional FETCH_TRACE_EN prints every bundle written to the output register.
`ifdef FETCH_TRACE_EN
`ifndef MSG
`define MSG(LVL, ARGS) $display ARGS
`endif
`endif

module fetch_stage
  import stage::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned BOOT_ADDR  = 0
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam int WA = ADDR_WIDTH - 2;

  fetch_state_e  state_q, state_d;
  logic [WA-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
  logic          drop_q, drop_d, out_valid_q, out_valid_d;
  InsnBundle     out_insn_q, out_insn_d, rsp_bundle, skid_data;
  logic          skid_valid, skid_load, skid_unload, skid_flush;
  logic          out_load, out_sel_skid, accept;

  assign rsp_bundle = '{addr: WORD_ADDR_W'(req_addr_q), insn: bus.imem_rsp_data};
  assign accept     = (state_q == REQ) && bus.imem_req_ready;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (skid_flush),
    .data_i   (rsp_bundle),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q & bus.stall;
    out_load     = 1'b0;
    out_sel_skid = 1'b0;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_flush   = 1'b0;
    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_addr;
      out_valid_d = 1'b0;
      skid_flush  = 1'b0 | 1'b1;
      // A response landing this very cycle is the outstanding one: nothing left to drop.
      if (accept || (state_q == WAIT && !bus.imem_rsp_valid)) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        BOOT: state_d = REQ;
        REQ: if (bus.imem_req_ready) begin
          pc_d       = pc_q + WA'(1);
          req_addr_d = pc_q;
          state_d    = WAIT;
        end
        WAIT: if (bus.imem_rsp_valid) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!out_valid_q || !bus.stall) begin
            out_load    = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: if (!bus.stall && skid_valid) begin
          out_load     = 1'b1;
          out_sel_skid = 1'b1;
          out_valid_d  = 1'b1;
          skid_unload  = 1'b1;
          state_d      = REQ;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign out_insn_d = !out_load ? out_insn_q : (out_sel_skid ? skid_data : rsp_bundle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= WA'(BOOT_ADDR);
      req_addr_q  <= WA'(BOOT_ADDR);
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_insn_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_insn_q  <= out_insn_d;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && out_load)
      `MSG(5, ("FETCH: addr=%h op=%h", {out_insn_d.addr, 2'b00}, out_insn_d.insn));
  end
`endif

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_insn       = out_insn_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: random imem latency/stall/redirect against a transaction-level model.
module tb_fetch_stage;
  import stage::*;

  localparam logic [29:0] BOOT = 30'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(32)) bus();
  fetch_stage #(.ADDR_WIDTH(32), .BOOT_ADDR(32'h100)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_pass = 0, n_cons = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // stimulus knobs
  int p_ready = 100, p_stall = 0, p_redir = 0, dly_min = 1, dly_max = 1, stall_mode = 2;
  bit rst_req = 1'b1, force_redir = 1'b0, data_ovr_en = 1'b0;
  logic [29:0] force_addr;
  logic [31:0] data_ovr;

  // memory: at most one response in flight
  bit mem_pend = 1'b0, mem_live = 1'b0;
  int mem_cnt = 0;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;

  // model: next fetch address and bundles owed to the read stage, oldest first
  logic [29:0] pc_m = BOOT;
  InsnBundle exp_q[$];

  task automatic step();
    bit rsp_now, rsp_live, redir, accept, stl;
    logic [29:0] rsp_a, ra;
    logic [31:0] rsp_d;
    @(negedge clk);
    rsp_now = 1'b0; rsp_live = 1'b0; rsp_a = '0; rsp_d = '0;
    rst = rst_req;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_pend = 1'b0; rsp_now = 1'b1; rsp_live = mem_live;
        rsp_a = mem_addr; rsp_d = mem_data;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data;
      end
    end
    bus.imem_req_ready = !rst_req && ($urandom_range(0, 99) < p_ready);
    stl = (stall_mode == 1) || (stall_mode == 0 && $urandom_range(0, 99) < p_stall);
    bus.stall = stl;
    redir = !rst_req && (force_redir || ($urandom_range(0, 99) < p_redir));
    ra = force_redir ? force_addr :
         ($urandom_range(0, 1) ? 30'($urandom) : 30'h3FFFFFFC + 30'($urandom_range(0, 3)));
    bus.redirect_valid = redir;
    bus.redirect_addr  = ra;
    #1;
    chk("out_valid", bus.out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("out_insn", bus.out_insn, exp_q[0]);
    accept = bus.imem_req_valid && bus.imem_req_ready;
    if (rst_req) begin
      exp_q.delete();
      mem_live = 1'b0;
      pc_m = BOOT;
    end else begin
      if (bus.out_valid && !stl && !redir && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_cons++;
      end
      if (accept) begin
        chk("req_addr", bus.imem_req_addr, pc_m);
        chk("one_outstanding", mem_pend || rsp_now, 0);
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(dly_min, dly_max);
        mem_addr = bus.imem_req_addr;
        mem_data = data_ovr_en ? data_ovr : $urandom;
        mem_live = !redir;
      end
      if (rsp_now && rsp_live && !redir) exp_q.push_back('{addr: rsp_a, insn: rsp_d});
      if (redir) begin
        exp_q.delete();
        mem_live = 1'b0;
        pc_m = ra;
      end else if (accept) begin
        pc_m = pc_m + 30'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    InsnBundle x;
    int c0, k;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_insn", bus.out_insn, 0);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_req_addr", bus.imem_req_addr, BOOT);

    // boot: BOOT cycle then first request, one bundle every two cycles
    rst_req = 1'b0;
    chk("boot_no_req", bus.imem_req_valid, 0);
    step();
    chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_req_addr", bus.imem_req_addr, BOOT);
    repeat (4) step();
    c0 = n_cons;
    repeat (20) step();
    chk("throughput", n_cons - c0, 10);

    // stall while a response arrives: skid holds it, nothing lost
    k = 0;
    while (!(bus.out_valid && bus.imem_req_valid) && k < 10) begin step(); k++; end
    chk("stall_sync", bus.out_valid && bus.imem_req_valid, 1);
    x = exp_q[0];
    data_ovr = 32'hDEADBEEF; data_ovr_en = 1'b1; stall_mode = 1;
    for (int j = 0; j < 5; j++) begin
      step();
      data_ovr_en = 1'b0;
      chk("hold_out", bus.out_insn, x);
      chk("hold_noreq", bus.imem_req_valid, 0);
    end
    stall_mode = 2;
    step();
    chk("skid_out", bus.out_insn.insn, 32'hDEADBEEF);

    // redirect while waiting: in-flight response dropped
    dly_min = 3; dly_max = 3;
    k = 0;
    do begin step(); k++; end while (!(mem_pend && mem_cnt >= 2) && k < 10);
    force_redir = 1'b1; force_addr = 30'h200;
    step();
    force_redir = 1'b0;
    chk("redir_flush", bus.out_valid, 0);
    k = 0;
    while (!bus.imem_req_valid && k < 10) begin step(); k++; end
    chk("redir_req", bus.imem_req_addr, 30'h200);

    // redirect coincident with the response
    dly_min = 2; dly_max = 2;
    k = 0;
    do begin step(); k++; end while (!(mem_pend && mem_cnt == 1) && k < 10);
    force_redir = 1'b1; force_addr = 30'h300;
    step();
    force_redir = 1'b0;
    chk("redir_rsp_req_v", bus.imem_req_valid, 1);
    chk("redir_rsp_req_a", bus.imem_req_addr, 30'h300);

    // PC wrap
    dly_min = 1; dly_max = 1;
    force_redir = 1'b1; force_addr = 30'h3FFFFFFF;
    step();
    force_redir = 1'b0;
    k = 0;
    while (!bus.imem_req_valid && k < 10) begin step(); k++; end
    chk("wrap_top", bus.imem_req_addr, 30'h3FFFFFFF);
    step();
    k = 0;
    while (!bus.imem_req_valid && k < 10) begin step(); k++; end
    chk("wrap_zero", bus.imem_req_addr, 0);

    // reset while waiting, stale response lands during BOOT
    dly_min = 2; dly_max = 2;
    k = 0;
    do begin step(); k++; end while (!(mem_pend && mem_cnt == 2) && k < 10);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("rst_stale_out", bus.out_valid, 0);
    k = 0;
    while (!bus.imem_req_valid && k < 10) begin step(); k++; end
    chk("rst_first_req", bus.imem_req_addr, BOOT);

    // random traffic
    p_ready = 70; p_stall = 30; p_redir = 4; dly_min = 1; dly_max = 3; stall_mode = 0;
    repeat (800) step();
    p_redir = 0; stall_mode = 2;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch pipeline stage: the stage directly upstream of the read stage. Owns the program counter, issues one word-aligned request at a time to instruction memory, and packs each response into a `stage::InsnBundle` for the read stage. Handles downstream stall via a one-entry skid register and redirects (branches, traps) via a drop-on-flight mechanism.

## Interface
Parameters:
- ADDR_WIDTH, 32: byte address width. Word address is ADDR_WIDTH-2 bits, bits [ADDR_WIDTH-1:2]; instructions are 4 bytes.
- BOOT_ADDR, 0: word address fetched first after reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  ADDR_WIDTH-2  word address of request.
- imem_req_ready  in  1  memory accepts request when high with valid.
- imem_rsp_valid  in  1  response data valid, one cycle per accepted request, never in the same cycle as acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch at redirect_addr.
- redirect_addr  in  ADDR_WIDTH-2  new word address.
- stall  in  1  read stage cannot take out_insn this cycle.
- out_valid  out  1  out_insn holds a live instruction.
- out_insn  out  stage::InsnBundle  {addr: word address, insn: 32-bit word}, registered.

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD.
- BOOT: entered on reset, lasts exactly one cycle, then REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready: pc <= pc+1 (wraps modulo 2^(ADDR_WIDTH-2)), latch request address in req_addr, go to WAIT.
- WAIT: on imem_rsp_valid: if output slot free (!out_valid or !stall), load out_insn={req_addr, imem_rsp_data}, out_valid=1, go to REQ; otherwise load skid register, go to HOLD.
- HOLD: no request issued. When !stall: skid moves to out_insn, out_valid=1, go to REQ.
- Output consumption: out_valid && !stall means the read stage took the bundle; with no new data that cycle, out_valid <= 0.
- Redirect (highest priority, any state): pc <= redirect_addr; out_valid <= 0; skid discarded. If a request is outstanding (WAIT, or REQ with imem_req_ready this cycle), set drop flag and go to WAIT; the next response is discarded, drop cleared, then REQ. Otherwise go to REQ.
- Redirect and imem_rsp_valid in the same cycle: response discarded, no drop flag set (that response was the outstanding one).
- Redirect overrides stall: output flushed even while stalled.
- At most one outstanding request at any time.

## Timing
- Reset values: out_valid=0, out_insn=0, imem_req_valid=0, imem_req_addr=BOOT_ADDR, pc=BOOT_ADDR, drop=0, state=BOOT.
- First imem_req_valid: second cycle after rst deasserts.
- Latency: response at cycle M appears on out_insn/out_valid at M+1.
- Steady state with single-cycle memory and no stall: one instruction every 2 cycles (REQ, WAIT).
- Redirect at cycle N: out_valid=0 at N+1; request to redirect_addr no earlier than N+1 (no outstanding) or the cycle after the dropped response.
- rst mid-operation: state returns to BOOT next cycle; any in-flight response arriving after reset is ignored because the FSM is not in WAIT.

## Configuration
- FETCH_TRACE_EN defined: on each bundle written to out_insn, emit `MSG(5, "FETCH: addr=%h op=%h") with byte address {addr, 2'b00} and insn; skip during rst.
- Not defined: no trace code compiled; RTL behaviour identical.

## Structure
- stage package: existing InsnBundle; add fetch_state_e enum (BOOT, REQ, WAIT, HOLD) and constant INSN_SIZE=4.
- One sub-module: fetch_skid_buffer (one-entry InsnBundle register with valid, load/unload/flush).

## Test plan
- Reset, BOOT_ADDR=0x100, 1-cycle memory, no stall -> requests 0x100,0x101,0x102; out_insn.addr follows, one bundle every 2 cycles.
- Hold stall=1 for 5 cycles while response 0xDEADBEEF arrives with out_valid=1 -> state HOLD, no new request, out_insn unchanged; after release skid bundle appears next cycle, none lost or duplicated.
- Redirect to 0x200 while in WAIT -> next response dropped, next request addr=0x200, no bundle from old path reaches output.
- Redirect and imem_rsp_valid same cycle -> response discarded, request to redirect_addr the following cycle, drop flag stays 0.
- pc=2^(ADDR_WIDTH-2)-1 accepted -> next request addr=0.
- rst asserted in WAIT, response arrives a cycle later -> out_valid stays 0, first post-reset request is BOOT_ADDR.
